// File: rtl/bus_responder.sv
// bus_responder: CPU bus responder with wait-state insertion, registered read path and an optional IO timer.
//
// Ports:
//   clock       sole clock, all state on posedge
//   reset       synchronous, active-high
//   address     CPU bus address
//   out         CPU write data
//   we          CPU write strobe
//   in          read data to CPU (1-cycle latency)
//   hold        1 = CPU may advance, 0 = stall
//   intr        active-high level interrupt
//   mem_address external synchronous RAM address (combinational copy of address)
//   mem_wdata   RAM write data (combinational copy of out)
//   mem_we      RAM write enable
//   mem_rdata   RAM read data, valid 1 cycle after address
//
// Configuration: define BUS_RESPONDER_TIMER_EN to build the timer behind IO offsets 0..3.
// Without it the IO window reads 8'h00, ignores writes and intr is tied low.
module bus_responder #(
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] SLOW_BASE   = 16'hE000,
    parameter logic [15:0] IO_BASE     = 16'hC000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [7:0]  out,
    input  logic        we,
    output logic [7:0]  in,
    output logic        hold,
    output logic        intr,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT    = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;
    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES - 1);

    logic [1:0] state;
    logic [3:0] cnt;
    logic       io_hit;
    logic       slow_hit;
    logic       sel_io_q;
    logic [7:0] io_q;
    logic [7:0] io_rd;

    assign mem_address = address;
    assign mem_wdata   = out;
    assign io_hit      = address[15:4] == IO_BASE[15:4];
    assign slow_hit    = !io_hit && address >= SLOW_BASE;
    // Reset forces hold high so an in-flight slow access is abandoned cleanly.
    assign hold        = reset || (state == IDLE ? !slow_hit : state == RELEASE);
    assign mem_we      = !reset && we && !io_hit && hold;
    assign in          = sel_io_q ? io_q : mem_rdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: if (slow_hit) begin
                    state <= WAIT;
                    cnt   <= WS_LOAD;
                end
                WAIT: if (cnt == 4'd0) state <= RELEASE;
                      else cnt <= cnt - 4'd1;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sel_io_q <= 1'b1;
            io_q     <= 8'h00;
        end else begin
            sel_io_q <= io_hit;
            io_q     <= io_rd;
        end
    end

`ifdef BUS_RESPONDER_TIMER_EN
    logic [15:0] reload;
    logic [15:0] count;
    logic [1:0]  ctrl;
    logic        pending;
    logic        running;
    logic        expire;
    logic        io_wr;
    logic [3:0]  off;

    assign off    = address[3:0];
    assign io_wr  = !reset && we && io_hit && hold;
    // count==0 while running only happens after a zero reload; it expires at once.
    assign expire = running && count <= 16'd1;
    assign intr   = pending && ctrl[0];

    always_comb begin
        io_rd = off == 4'd0 ? reload[7:0] :
                off == 4'd1 ? reload[15:8] :
                off == 4'd2 ? {6'd0, running, pending} :
                off == 4'd3 ? {6'd0, ctrl} : 8'h00;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            reload  <= 16'd0;
            count   <= 16'd0;
            ctrl    <= 2'd0;
            pending <= 1'b0;
            running <= 1'b0;
        end else begin
            if (io_wr && off == 4'd0) reload[7:0] <= out;
            if (io_wr && off == 4'd3) ctrl <= out[1:0];
            // An expiry in the same cycle as a clear keeps pending set.
            if (expire || (io_wr && off == 4'd2 && out[0])) pending <= expire;
            if (io_wr && off == 4'd1) begin
                reload[15:8] <= out;
                count        <= {out, reload[7:0]};
                running      <= 1'b1;
            end else if (expire) begin
                count   <= ctrl[1] ? reload : 16'd0;
                running <= ctrl[1];
            end else if (running) begin
                count <= count - 16'd1;
            end
        end
    end
`else
    assign io_rd = 8'h00;
    assign intr  = 1'b0;
`endif
endmodule

// File: tb/tb_bus_responder.sv
// tb_bus_responder: randomized and directed check of bus_responder against a behavioural model.
module tb_bus_responder;
    localparam int WS = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] address = 16'h0000;
    logic [7:0]  out = 8'h00;
    logic        we = 1'b0;
    logic [7:0]  in;
    logic        hold;
    logic        intr;
    logic [15:0] mem_address;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;

    bus_responder dut (
        .clock(clock), .reset(reset), .address(address), .out(out), .we(we),
        .in(in), .hold(hold), .intr(intr), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    logic [7:0] ram   [65536];
    logic [7:0] ram_m [65536];

    always @(posedge clock) begin
        mem_rdata <= ram[mem_address];
        if (mem_we) ram[mem_address] <= mem_wdata;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: stall length as a remaining-cycle count, timer as a schedule of expiry cycles.
    int          m_left = 0;
    bit          m_rel = 0;
    logic        p_sel = 1'b1;
    logic [7:0]  p_io = 8'h00;
    logic [7:0]  p_rd = 8'h00;
    logic        last_hold = 1'b1;
    longint      cyc = 0;
    logic [15:0] t_reload = 16'd0;
    logic [1:0]  t_ctrl = 2'd0;
    bit          t_pend = 0;
    bit          t_run = 0;
    longint      t_next = 0;

    function automatic logic [7:0] io_read(input logic [3:0] o);
`ifdef BUS_RESPONDER_TIMER_EN
        case (o)
            4'd0: return t_reload[7:0];
            4'd1: return t_reload[15:8];
            4'd2: return {6'd0, t_run, t_pend};
            4'd3: return {6'd0, t_ctrl};
            default: return 8'h00;
        endcase
`else
        return 8'h00 | {4'd0, o & 4'd0};
`endif
    endfunction

    always @(negedge clock) begin : model
        logic io, slow, e_hold, e_we, ex;
        logic [3:0] o;
        cyc++;
        io = address[15:12] == 4'hC && address[11:4] == 8'h00;
        slow = !io && address >= 16'hE000;
        o = address[3:0];
        chk("mem_address", mem_address, address);
        chk("mem_wdata", {8'h00, mem_wdata}, {8'h00, out});
        if (reset) begin
            chk("hold_rst", {15'd0, hold}, 16'd1);
            chk("mem_we_rst", {15'd0, mem_we}, 16'd0);
            m_left = 0; m_rel = 0; p_sel = 1'b1; p_io = 8'h00; last_hold = 1'b1;
            t_reload = 16'd0; t_ctrl = 2'd0; t_pend = 0; t_run = 0;
        end else begin
            e_hold = m_left > 0 ? 1'b0 : m_rel ? 1'b1 : !slow;
            e_we = we && !io && e_hold;
            chk("hold", {15'd0, hold}, {15'd0, e_hold});
            chk("mem_we", {15'd0, mem_we}, {15'd0, e_we});
            chk("in", {8'h00, in}, {8'h00, p_sel ? p_io : p_rd});
            chk("intr", {15'd0, intr}, {15'd0, t_pend && t_ctrl[0]});
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_rel = 1;
            end else if (m_rel) m_rel = 0;
            else if (slow) m_left = WS;
            p_rd = ram_m[address];
            if (e_we) ram_m[address] = out;
            p_sel = io;
            p_io = io_read(o);
`ifdef BUS_RESPONDER_TIMER_EN
            ex = t_run && cyc == t_next;
            if (ex) begin
                t_pend = 1;
                if (t_ctrl[1]) t_next = cyc + (t_reload == 16'd0 ? 1 : longint'(t_reload));
                else t_run = 0;
            end
            if (io && we && e_hold) begin
                if (o == 4'd0) t_reload[7:0] = out;
                if (o == 4'd1) begin
                    t_reload[15:8] = out;
                    t_run = 1;
                    t_next = cyc + (t_reload == 16'd0 ? 1 : longint'(t_reload));
                end
                if (o == 4'd2 && out[0] && !ex) t_pend = 0;
                if (o == 4'd3) t_ctrl = out[1:0];
            end
`else
            ex = 1'b0;
`endif
            last_hold = e_hold;
        end
    end

    task automatic step(input logic r, input logic [15:0] a, input logic w, input logic [7:0] d);
        @(posedge clock);
        #1;
        reset = r; address = a; we = w; out = d;
        @(negedge clock);
        #1;
    endtask

    logic [15:0] cur_a;
    logic        cur_w;
    logic [7:0]  cur_d;

    initial begin
        for (int a = 0; a < 65536; a++) begin
            ram[a] = 8'(a) ^ 8'(a >> 8) ^ 8'h3C;
            ram_m[a] = ram[a];
        end
        ram[16'h0200] = 8'h5A; ram_m[16'h0200] = 8'h5A;
        ram[16'hF000] = 8'h77; ram_m[16'hF000] = 8'h77;
        ram[16'hE000] = 8'h11; ram_m[16'hE000] = 8'h11;

        repeat (3) step(1, 16'h0000, 0, 8'h00);
        step(0, 16'h0000, 0, 8'h00);
        chk("lit_reset_hold", {15'd0, hold}, 16'd1);
        chk("lit_reset_in", {8'h00, in}, 16'h0000);
        chk("lit_reset_intr", {15'd0, intr}, 16'd0);

        step(0, 16'h0200, 0, 8'h00);
        chk("lit_fast_hold", {15'd0, hold}, 16'd1);
        step(0, 16'h0000, 0, 8'h00);
        chk("lit_fast_in", {8'h00, in}, 16'h005A);

        for (int i = 0; i < 3; i++) begin
            step(0, 16'hF000, 0, 8'h00);
            chk("lit_slow_stall", {15'd0, hold}, 16'd0);
        end
        step(0, 16'hF000, 0, 8'h00);
        chk("lit_slow_release", {15'd0, hold}, 16'd1);
        chk("lit_slow_no_we", {15'd0, mem_we}, 16'd0);
        step(0, 16'h0000, 0, 8'h00);
        chk("lit_slow_in", {8'h00, in}, 16'h0077);

        for (int i = 0; i < 3; i++) begin
            step(0, 16'hE010, 1, 8'hA5);
            chk("lit_sw_no_we", {15'd0, mem_we}, 16'd0);
        end
        step(0, 16'hE010, 1, 8'hA5);
        chk("lit_sw_we", {15'd0, mem_we}, 16'd1);
        chk("lit_sw_wdata", {8'h00, mem_wdata}, 16'h00A5);
        step(0, 16'h0000, 0, 8'h00);
        chk("lit_sw_done", {15'd0, mem_we}, 16'd0);

        step(0, 16'hE000, 1, 8'h99);
        step(0, 16'hE000, 1, 8'h99);
        step(1, 16'hE000, 1, 8'h99);
        chk("lit_rstwait_we", {15'd0, mem_we}, 16'd0);
        step(0, 16'h0000, 0, 8'h00);
        chk("lit_rstwait_hold", {15'd0, hold}, 16'd1);
        for (int i = 0; i < 4; i++) step(0, 16'hE000, 0, 8'h00);
        step(0, 16'h0000, 0, 8'h00);
        chk("lit_rstwait_kept", {8'h00, in}, 16'h0011);

`ifdef BUS_RESPONDER_TIMER_EN
        step(0, 16'hC003, 1, 8'h01);
        step(0, 16'hC000, 1, 8'h03);
        step(0, 16'hC001, 1, 8'h00);
        step(0, 16'h0000, 0, 8'h00);
        step(0, 16'h0000, 0, 8'h00);
        step(0, 16'h0000, 0, 8'h00);
        chk("lit_tmr_not_yet", {15'd0, intr}, 16'd0);
        step(0, 16'h0000, 0, 8'h00);
        chk("lit_tmr_rise", {15'd0, intr}, 16'd1);
        step(0, 16'hC002, 1, 8'h01);
        chk("lit_tmr_clr_cycle", {15'd0, intr}, 16'd1);
        step(0, 16'hC002, 0, 8'h00);
        chk("lit_tmr_cleared", {15'd0, intr}, 16'd0);
        step(0, 16'h0000, 0, 8'h00);
        chk("lit_tmr_status", {8'h00, in}, 16'h0000);

        step(0, 16'hC003, 1, 8'h03);
        step(0, 16'hC000, 1, 8'h02);
        step(0, 16'hC001, 1, 8'h00);
        step(0, 16'h0000, 0, 8'h00);
        step(0, 16'h0000, 0, 8'h00);
        step(0, 16'hC002, 1, 8'h01);
        chk("lit_ar_first", {15'd0, intr}, 16'd1);
        step(0, 16'hC002, 1, 8'h01);
        chk("lit_ar_cleared", {15'd0, intr}, 16'd0);
        step(0, 16'h0000, 0, 8'h00);
        chk("lit_ar_set_wins", {15'd0, intr}, 16'd1);
        step(0, 16'h0000, 0, 8'h00);
        step(0, 16'hC002, 1, 8'h01);
        step(0, 16'h0000, 0, 8'h00);
        chk("lit_ar_period_lo", {15'd0, intr}, 16'd0);
        step(0, 16'h0000, 0, 8'h00);
        chk("lit_ar_period_hi", {15'd0, intr}, 16'd1);
        step(0, 16'hC003, 1, 8'h00);
        step(0, 16'hC002, 1, 8'h01);
`else
        step(0, 16'hC000, 1, 8'h5A);
        step(0, 16'hC000, 0, 8'h00);
        step(0, 16'h0000, 0, 8'h00);
        chk("lit_io_off", {8'h00, in}, 16'h0000);
        chk("lit_intr_off", {15'd0, intr}, 16'd0);
`endif

        cur_a = 16'h0000; cur_w = 1'b0; cur_d = 8'h00;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                step(1, cur_a, cur_w, cur_d);
                continue;
            end
            if (last_hold) begin
                int k;
                k = $urandom_range(0, 11);
                cur_w = $urandom_range(0, 1) == 1;
                cur_d = 8'($urandom);
                if (k <= 2) cur_a = 16'($urandom_range(0, 255));
                else if (k <= 4) cur_a = $urandom_range(0, 1) ? 16'($urandom_range(16'hE000, 16'hE00F))
                                                              : 16'($urandom_range(16'hF000, 16'hF00F));
                else if (k <= 8) begin
                    cur_a = 16'hC000 | 16'($urandom_range(0, 5));
                    if ($urandom_range(0, 5) == 0) cur_a = 16'hC00F;
                    cur_d = cur_a[3:0] == 4'd1 ? 8'h00 : 8'($urandom_range(0, 5));
                end else if (k == 9) cur_a = 16'hDFFF;
                else if (k == 10) cur_a = 16'hC010;
                else cur_a = 16'hBFFF;
            end
            step(0, cur_a, cur_w, cur_d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 Parameter WAIT_STATES, default 2, range 1..15: hold-low cycles inserted per slow-region access.
REQ-002 Parameter SLOW_BASE, default 16'hE000: addresses >= SLOW_BASE are the slow region.
REQ-003 Parameter IO_BASE, default 16'hC000: 16-byte IO window IO_BASE..IO_BASE+15.
REQ-004 Ports SHALL be as follows; there is one clock, and reset is synchronous and active-high:
- clock  in  1  sole clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- address  in  16  CPU bus address.
- out  in  8  CPU write data.
- we  in  1  CPU write strobe.
- in  out  8  read data to CPU.
- hold  out  1  1 = CPU may advance, 0 = stall.
- intr  out  1  active-high level interrupt to CPU.
- mem_address  out  16  external synchronous RAM address.
- mem_wdata  out  8  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_rdata  in  8  RAM read data, valid 1 cycle after address.

Function
REQ-005 mem_address SHALL equal address and mem_wdata SHALL equal out, both combinationally.
REQ-006 io_hit = address[15:4] == IO_BASE[15:4]; slow_hit = !io_hit && address >= SLOW_BASE.
REQ-007 FSM states: IDLE, WAIT, RELEASE; reset state IDLE.
REQ-008 IDLE with slow_hit: hold = 0 combinationally; go to WAIT; load cnt = WAIT_STATES-1.
REQ-009 IDLE without slow_hit: hold = 1; stay in IDLE.
REQ-010 WAIT: hold = 0; if cnt == 0, go to RELEASE, else decrement cnt.
REQ-011 RELEASE: hold = 1 for exactly one cycle, then go to IDLE, regardless of address.
REQ-012 A slow access SHALL therefore stall for exactly WAIT_STATES+1 cycles with hold = 0, followed by one hold = 1 cycle.
REQ-013 mem_we = we && !io_hit && hold; a slow write commits only in its RELEASE cycle.
REQ-014 in is the registered read path with 1-cycle latency: in = sel_io_q ? io_q : mem_rdata, where sel_io_q and io_q are io_hit and the IO read value, registered every cycle.
REQ-015 IO map, offsets 0..3: TLO (reload[7:0], R/W); THI (reload[15:8], R/W); STATUS (bit0 pending, bit1 running; writing 1 to bit0 clears pending); CTRL (bit0 irq enable, bit1 auto-reload, R/W); offsets 4..15 read 8'h00 and ignore writes.
REQ-016 A write to THI, when hold = 1, SHALL load count <= {THI_new, TLO} and set running; a write while running restarts the count.
REQ-017 While running, count decrements by 1 per cycle; on 1->0: set pending; if auto-reload, count <= reload, else clear running.
REQ-018 A reload value of 0 written to THI SHALL set pending on the next cycle and follow REQ-017.
REQ-019 intr = pending && CTRL.bit0.
REQ-020 If a STATUS clear and a timer expiry occur in the same cycle, the set wins and pending = 1.
REQ-021 IO writes are accepted only when hold = 1; IO accesses never stall.

Reset
REQ-022 On reset: state IDLE, cnt 0, hold 1, in 8'h00, intr 0, mem_we 0, reload 0, count 0, pending 0, running 0, CTRL 0.
REQ-023 Reset asserted in WAIT or RELEASE SHALL give hold = 1 and state IDLE in the next cycle, and SHALL drop any pending slow write.

Configuration
REQ-024 Macro BUS_RESPONDER_TIMER_EN defined: the timer and IO offsets 0..3 behave as in REQ-015..REQ-020.
REQ-025 Macro BUS_RESPONDER_TIMER_EN undefined: no timer logic; the whole IO window reads 8'h00 and ignores writes; intr is tied to 0. Wait-state behaviour is unchanged.

Verification
REQ-026 Read at 16'h0200 with RAM holding 8'h5A: hold stays 1; in = 8'h5A one cycle later.
REQ-027 Read at 16'hF000 with WAIT_STATES = 2: hold = 0 for 3 cycles, then 1 for one cycle; in valid the following cycle; no mem_we.
REQ-028 Write 8'hA5 to 16'hE010: mem_we pulses exactly once, in the RELEASE cycle, with mem_wdata = 8'hA5.
REQ-029 Write CTRL = 8'h01, TLO = 8'h03, THI = 8'h00: intr rises 3 cycles after the THI write; writing STATUS = 8'h01 drops intr next cycle; running = 0.
REQ-030 Auto-reload with reload 2 and a STATUS clear issued on the expiry cycle: pending stays 1; expiries repeat every 2 cycles.
REQ-031 Reset asserted on the second WAIT cycle: next cycle hold = 1, state IDLE, no mem_we.
